// File: rtl/bus_cycle_sequencer_pkg.sv
// Shared types and constants for the bus cycle sequencer: FSM state
// encoding, default bus timing and the read/write op encoding.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_e;

  localparam int ADDR_W_DEF     = 2;
  localparam int DATA_W_DEF     = 8;
  localparam int SETUP_CYC_DEF  = 1;
  localparam int STROBE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF   = 1;
  localparam int CNT_W_DEF      = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// Request/bus interface of the bus cycle sequencer.
// Optional macro BUS_CYCLE_READY_EN adds the READY input and wait_cnt output.
// The sequencer uses the slave modport; requesters and the bus model use master.
interface bus_cycle_sequencer_if
  import bus_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic [1:0]          req;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          gnt;
  logic [1:0]          done;
  logic [DATA_W-1:0]   rdata;
  logic [ADDR_W-1:0]   A;
  logic [DATA_W-1:0]   DOUT;
  logic                DOUT_oe;
  logic [DATA_W-1:0]   DIN;
  logic                WR_n;
  logic                RD_n;
  logic                busy;
`ifdef BUS_CYCLE_READY_EN
  logic                READY;
  logic [CNT_W-1:0]    wait_cnt;
`endif

  modport slave (
    input  req, req_we, req_addr, req_wdata, DIN,
`ifdef BUS_CYCLE_READY_EN
    input  READY,
    output wait_cnt,
`endif
    output gnt, done, rdata, A, DOUT, DOUT_oe, WR_n, RD_n, busy
  );

  modport master (
    output req, req_we, req_addr, req_wdata, DIN,
`ifdef BUS_CYCLE_READY_EN
    output READY,
    input  wait_cnt,
`endif
    input  gnt, done, rdata, A, DOUT, DOUT_oe, WR_n, RD_n, busy
  );

endinterface

// File: rtl/bus_cycle_sequencer_rr_arbiter2.sv
// Two-input round-robin arbiter. The pointer names the requester with
// priority; after a grant it points at the requester that did not win.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr_next
);

  // Pick the first requesting index starting at the pointer.
  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr;
    if (en) begin
      if (req[ptr]) begin
        gnt[ptr] = 1'b1;
        ptr_next = ~ptr;
      end else if (req[~ptr]) begin
        gnt[~ptr] = 1'b1;
        ptr_next  = ptr;
      end
    end
  end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: arbitrates two internal requesters and runs one
// external bus cycle at a time (SETUP -> STROBE -> HOLD) with programmable
// phase lengths. All bus outputs are registered.
// Optional macro BUS_CYCLE_READY_EN: READY stretches the last strobe cycle,
// wait_cnt reports the number of stretch cycles.
module bus_cycle_sequencer
  import bus_seq_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  bus_cycle_sequencer_if.slave bif
);

  localparam bit PARAMS_OK =
    (SETUP_CYC >= 1) && (STROBE_CYC >= 1) && (HOLD_CYC >= 1) &&
    (SETUP_CYC < (1 << CNT_W)) && (STROBE_CYC < (1 << CNT_W)) &&
    (HOLD_CYC < (1 << CNT_W));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $fatal(1, "bus_cycle_sequencer: phase lengths must be >=1 and < 2**CNT_W");
    end
  endgenerate

  // Counter load values: the counter runs down to zero on the last phase cycle.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_oe_q, dout_oe_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_n_q, wr_n_d;
  logic              rd_n_q, rd_n_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
`ifdef BUS_CYCLE_READY_EN
  logic [CNT_W-1:0]  wait_q, wait_d;
`endif

  logic [1:0] arb_gnt;
  logic       arb_ptr_next;
  logic       strobe_end;
  logic       win;

  rr_arbiter2 u_arb (
    .req      (bif.req),
    .ptr      (ptr_q),
    .en       (state_q == IDLE),
    .gnt      (arb_gnt),
    .ptr_next (arb_ptr_next)
  );

  // Next-state and next-output logic of the bus cycle FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    dout_d     = dout_q;
    dout_oe_d  = dout_oe_q;
    rdata_d    = rdata_q;
    wr_n_d     = wr_n_q;
    rd_n_d     = rd_n_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    strobe_end = 1'b0;
    win        = arb_gnt[1];
`ifdef BUS_CYCLE_READY_EN
    wait_d     = wait_q;
`endif

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          gnt_d     = arb_gnt;
          owner_d   = win;
          op_d      = win ? bif.req_we[1] : bif.req_we[0];
          a_d       = win ? bif.req_addr[2*ADDR_W-1:ADDR_W] : bif.req_addr[ADDR_W-1:0];
          dout_d    = win ? bif.req_wdata[2*DATA_W-1:DATA_W] : bif.req_wdata[DATA_W-1:0];
          dout_oe_d = (op_d == OP_WRITE);
          ptr_d     = arb_ptr_next;
          cnt_d     = SETUP_LOAD;
          state_d   = SETUP;
`ifdef BUS_CYCLE_READY_EN
          wait_d    = '0;
`endif
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
          wr_n_d  = (op_q != OP_WRITE);
          rd_n_d  = (op_q == OP_WRITE);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STROBE: begin
        if (cnt_q == '0) begin
`ifdef BUS_CYCLE_READY_EN
          if (bif.READY) begin
            strobe_end = 1'b1;
          end else if (wait_q != '1) begin
            wait_d = wait_q + 1'b1;
          end
`else
          strobe_end = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (strobe_end) begin
          if (op_q == OP_READ) begin
            rdata_d = bif.DIN;
          end
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          wr_n_d  = 1'b1;
          rd_n_d  = 1'b1;
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          state_d         = IDLE;
          done_d[owner_q] = 1'b1;
          dout_oe_d       = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      op_q      <= OP_READ;
      a_q       <= '0;
      dout_q    <= '0;
      dout_oe_q <= 1'b0;
      rdata_q   <= '0;
      wr_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
`ifdef BUS_CYCLE_READY_EN
      wait_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      a_q       <= a_d;
      dout_q    <= dout_d;
      dout_oe_q <= dout_oe_d;
      rdata_q   <= rdata_d;
      wr_n_q    <= wr_n_d;
      rd_n_q    <= rd_n_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
`ifdef BUS_CYCLE_READY_EN
      wait_q    <= wait_d;
`endif
    end
  end

  assign bif.gnt     = gnt_q;
  assign bif.done    = done_q;
  assign bif.rdata   = rdata_q;
  assign bif.A       = a_q;
  assign bif.DOUT    = dout_q;
  assign bif.DOUT_oe = dout_oe_q;
  assign bif.WR_n    = wr_n_q;
  assign bif.RD_n    = rd_n_q;
  assign bif.busy    = (state_q != IDLE);
`ifdef BUS_CYCLE_READY_EN
  assign bif.wait_cnt = wait_q;
`endif

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed testbench for bus_cycle_sequencer with default timing
// (setup 1, strobe 2, hold 1). Prints one line per bus transaction.
module tb_bus_cycle_sequencer;
  import bus_seq_pkg::*;

  localparam int STROBE_LEN = 2;

  logic clk;
  logic rst_n;

  bus_cycle_sequencer_if bif ();

  bus_cycle_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Measurements of the most recent transaction.
  int         m_gnt_cyc, m_done_cyc, m_wr_lo, m_rd_lo, m_strb_first;
  int         m_a_bad, m_d_bad, m_oe_bad, m_both_lo;
  logic [1:0] m_gnt_val, m_done_val;
  logic       m_busy_g;
  logic [7:0] m_rdata;
  logic [3:0] m_wait;

  // Watch one transaction from the cycle after req is applied until done.
  task automatic mon(input int max_c, input int hold, input logic [7:0] din,
                     input bit scramble, input logic [1:0] exp_a,
                     input logic [7:0] exp_d, input logic exp_oe);
    int k;
    m_gnt_cyc = -1; m_done_cyc = -1; m_wr_lo = 0; m_rd_lo = 0; m_strb_first = -1;
    m_a_bad = 0; m_d_bad = 0; m_oe_bad = 0; m_both_lo = 0;
    m_gnt_val = 2'b00; m_done_val = 2'b00; m_busy_g = 1'b0; m_rdata = 8'h00; m_wait = 4'h0;
    for (int c = 1; c <= max_c; c++) begin
      @(posedge clk); #1;
      if (bif.gnt != 2'b00 && m_gnt_cyc < 0) begin
        m_gnt_cyc = c;
        m_gnt_val = bif.gnt;
        m_busy_g  = bif.busy;
        bif.req   = bif.req & ~bif.gnt;
        if (scramble) begin
          bif.req_addr  = ~bif.req_addr;
          bif.req_wdata = ~bif.req_wdata;
        end
      end
      if (bif.busy) begin
        if (bif.A !== exp_a) m_a_bad++;
        if (bif.DOUT !== exp_d) m_d_bad++;
        if (bif.DOUT_oe !== exp_oe) m_oe_bad++;
      end
      if (!bif.WR_n) m_wr_lo++;
      if (!bif.RD_n) m_rd_lo++;
      if (!bif.WR_n && !bif.RD_n) m_both_lo++;
      if ((!bif.WR_n || !bif.RD_n) && m_strb_first < 0) m_strb_first = c;
      k = m_wr_lo + m_rd_lo;
      bif.DIN = (!bif.RD_n && k == STROBE_LEN + hold) ? din : 8'h11;
`ifdef BUS_CYCLE_READY_EN
      bif.READY = !((!bif.WR_n || !bif.RD_n) && k >= STROBE_LEN && k < STROBE_LEN + hold);
`endif
      if (bif.done != 2'b00) begin
        m_done_cyc = c;
        m_done_val = bif.done;
        m_rdata    = bif.rdata;
`ifdef BUS_CYCLE_READY_EN
        m_wait     = bif.wait_cnt;
`endif
        break;
      end
    end
    bif.DIN = 8'h00;
`ifdef BUS_CYCLE_READY_EN
    bif.READY = 1'b1;
`endif
    $display("txn: gnt=%b@%0d strobe@%0d wr_lo=%0d rd_lo=%0d done=%b@%0d rdata=%h",
             m_gnt_val, m_gnt_cyc, m_strb_first, m_wr_lo, m_rd_lo, m_done_val, m_done_cyc, m_rdata);
  endtask

  int         g_cyc [4];
  int         d_cyc [4];
  logic [1:0] g_val [4];
  logic [1:0] d_val [4];
  int         ng, nd, late_done;

  initial begin
    rst_n         = 1'b0;
    bif.req       = 2'b00;
    bif.req_we    = 2'b00;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.DIN       = 8'h00;
`ifdef BUS_CYCLE_READY_EN
    bif.READY     = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_n", 32'(bif.WR_n), 32'd1);
    chk("rst_rd_n", 32'(bif.RD_n), 32'd1);
    chk("rst_a", 32'(bif.A), 32'd0);
    chk("rst_dout", 32'(bif.DOUT), 32'd0);
    chk("rst_oe", 32'(bif.DOUT_oe), 32'd0);
    chk("rst_rdata", 32'(bif.rdata), 32'd0);
    chk("rst_gnt", 32'(bif.gnt), 32'd0);
    chk("rst_done", 32'(bif.done), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    rst_n = 1'b1;

    // Single write from requester 0.
    @(posedge clk); #1;
    bif.req = 2'b01; bif.req_we = 2'b01; bif.req_addr = 4'b00_10; bif.req_wdata = 16'h00A5;
    mon(15, 0, 8'h00, 1'b0, 2'd2, 8'hA5, 1'b1);
    chk("w_gnt_cyc", 32'(m_gnt_cyc), 32'd1);
    chk("w_gnt_val", 32'(m_gnt_val), 32'b01);
    chk("w_busy", 32'(m_busy_g), 32'd1);
    chk("w_strb_first", 32'(m_strb_first), 32'd2);
    chk("w_wr_lo", 32'(m_wr_lo), 32'd2);
    chk("w_rd_lo", 32'(m_rd_lo), 32'd0);
    chk("w_a_bad", 32'(m_a_bad), 32'd0);
    chk("w_d_bad", 32'(m_d_bad), 32'd0);
    chk("w_oe_bad", 32'(m_oe_bad), 32'd0);
    chk("w_done_cyc", 32'(m_done_cyc), 32'd5);
    chk("w_done_val", 32'(m_done_val), 32'b01);
    #0;
    chk("w_oe_after", 32'(bif.DOUT_oe), 32'd0);
    chk("w_busy_after", 32'(bif.busy), 32'd0);

    // Single read from requester 1.
    bif.req = 2'b10; bif.req_we = 2'b00; bif.req_addr = 4'b11_00; bif.req_wdata = 16'h0000;
    mon(15, 0, 8'h3C, 1'b0, 2'd3, 8'hA5, 1'b0);
    chk("r_gnt_val", 32'(m_gnt_val), 32'b10);
    chk("r_rd_lo", 32'(m_rd_lo), 32'd2);
    chk("r_wr_lo", 32'(m_wr_lo), 32'd0);
    chk("r_a_bad", 32'(m_a_bad), 32'd0);
    chk("r_oe_bad", 32'(m_oe_bad), 32'd0);
    chk("r_done_cyc", 32'(m_done_cyc), 32'd5);
    chk("r_done_val", 32'(m_done_val), 32'b10);
    chk("r_rdata", 32'(m_rdata), 32'h3C);

    // Both requesters held high for four transactions.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      g_cyc[i] = -1; d_cyc[i] = -1; g_val[i] = 2'b00; d_val[i] = 2'b00;
    end
    ng = 0; nd = 0;
    bif.req = 2'b11; bif.req_we = 2'b11; bif.req_addr = 4'b01_10; bif.req_wdata = 16'h2211;
    for (int c = 1; c <= 30 && nd < 4; c++) begin
      @(posedge clk); #1;
      if (bif.gnt != 2'b00 && ng < 4) begin
        g_cyc[ng] = c; g_val[ng] = bif.gnt; ng++;
        if (ng == 4) bif.req = 2'b00;
      end
      if (bif.done != 2'b00 && nd < 4) begin
        d_cyc[nd] = c; d_val[nd] = bif.done; nd++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      $display("txn: rr #%0d gnt=%b@%0d done=%b@%0d", i, g_val[i], g_cyc[i], d_val[i], d_cyc[i]);
      chk($sformatf("rr_gnt%0d", i), 32'(g_val[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("rr_done%0d", i), 32'(d_val[i]), (i % 2 == 0) ? 32'b01 : 32'b10);
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(g_cyc[i] - d_cyc[i-1]), 32'd1);
    end
    chk("rr_first_gnt", 32'(g_cyc[0]), 32'd1);

    // Reset during the strobe of a write from requester 0.
    @(posedge clk); #1;
    bif.req = 2'b01; bif.req_we = 2'b01; bif.req_addr = 4'b00_01; bif.req_wdata = 16'h0077;
    @(posedge clk); #1;
    bif.req = 2'b00;
    @(posedge clk); #1;
    chk("ar_in_strobe", 32'(bif.WR_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_n", 32'(bif.WR_n), 32'd1);
    chk("ar_oe", 32'(bif.DOUT_oe), 32'd0);
    chk("ar_busy", 32'(bif.busy), 32'd0);
    chk("ar_a", 32'(bif.A), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    late_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bif.done != 2'b00 || bif.busy) late_done++;
    end
    chk("ar_no_done", 32'(late_done), 32'd0);
    $display("txn: aborted write, idle cycles with activity=%0d", late_done);
    bif.req = 2'b11; bif.req_we = 2'b11; bif.req_addr = 4'b10_01; bif.req_wdata = 16'h4433;
    mon(15, 0, 8'h00, 1'b0, 2'd1, 8'h33, 1'b1);
    bif.req = 2'b00;
    chk("ar_next_gnt", 32'(m_gnt_val), 32'b01);
    chk("ar_next_done", 32'(m_done_cyc), 32'd5);

    // Operands change the cycle after grant; bus keeps the latched values.
    @(posedge clk); #1;
    bif.req = 2'b10; bif.req_we = 2'b10; bif.req_addr = 4'b01_00; bif.req_wdata = 16'h5A00;
    mon(15, 0, 8'h00, 1'b1, 2'd1, 8'h5A, 1'b1);
    chk("lt_gnt_val", 32'(m_gnt_val), 32'b10);
    chk("lt_a_bad", 32'(m_a_bad), 32'd0);
    chk("lt_d_bad", 32'(m_d_bad), 32'd0);
    chk("lt_both_lo", 32'(m_both_lo), 32'd0);
    chk("lt_done_val", 32'(m_done_val), 32'b10);

`ifdef BUS_CYCLE_READY_EN
    // READY low for three cycles at the last strobe cycle of a read.
    @(posedge clk); #1;
    bif.req = 2'b01; bif.req_we = 2'b00; bif.req_addr = 4'b00_11; bif.req_wdata = 16'h0000;
    mon(20, 3, 8'hC3, 1'b0, 2'd3, 8'h00, 1'b0);
    chk("rdy_rd_lo", 32'(m_rd_lo), 32'd5);
    chk("rdy_wait", 32'(m_wait), 32'd3);
    chk("rdy_done_cyc", 32'(m_done_cyc), 32'd8);
    chk("rdy_rdata", 32'(m_rdata), 32'hC3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
